serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial W-bit unsigned subtractor computing A − B one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the inverse-operation counterpart of the team's ripple-carry adder datapath. It also sits on the switch/display path and reports the raw two's-complement difference, the final borrow, and a sign/magnitude pair for display. Operands are captured on a start handshake, and results are flagged with a one-cycle done pulse.

## Interface
- W, 4, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  W  minuend, captured when start is accepted
- b  input  W  subtrahend, captured when start is accepted
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse; results valid from this cycle on
- diff  output  W  (a − b) mod 2^W
- borrow  output  1  final borrow out; 1 iff a < b
- neg  output  1  sign for display; equals borrow
- mag  output  W  |a − b| as unsigned: borrow ? (2^W − diff) mod 2^W : diff

## Operation
- FSM states:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1.
  - DONE: done=1, busy=0.
- IDLE & start: load shift registers ra←a and rb←b, clear the borrow register br=0, set cnt=0, clear the result shift register rd, then go to SHIFT.
- SHIFT, each edge:
  - d = ra[0]^rb[0]^br
  - bo = (~ra[0]&rb[0]) | (~(ra[0]^rb[0])&br)
  - rd ← {d, rd[W-1:1]}; ra, rb shift right; br ← bo; cnt ← cnt+1.
- SHIFT & cnt==W−1: the last bit is processed on this edge, and the state goes to DONE. On the same edge, diff ← {d, rd[W-1:1]}, borrow ← bo, neg ← bo, and mag is computed from the new diff and bo.
- DONE → IDLE unconditionally on the next edge.
- diff, borrow, neg and mag hold their values until the next completion. They are never updated mid-operation.
- start is ignored in SHIFT and DONE. No queuing: a pulse seen outside IDLE is lost.
- Arithmetic is strictly unsigned. No overflow flag.

## Timing
- Reset (rst_n=0 at any edge): state=IDLE, busy=0, done=0, diff=0, borrow=0, neg=0, mag=0, cnt=0, br=0, ra=rb=rd=0. Reset wins over start and over any in-flight operation.
- Start accepted at edge t. busy is high in cycles t..t+W−1. The final bit is processed at edge t+W−1+1 = t+W, and done is high for exactly the cycle following edge t+W.
- Latency is W clocks from the accepting edge to done rising.
- Throughput: with start held high, a new operation is accepted at the edge leaving DONE+IDLE. The accept-to-accept period is W+2 clocks (W SHIFT, 1 DONE, 1 IDLE).
- a and b may change freely after the accepting edge.
- Boundary: a=0, b=2^(W−1) gives diff=2^(W−1), borrow=1, mag=2^(W−1). mag always fits in W bits.

## Structure
- Shared package holds:
  - state type: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10
  - default width constant W=4
  - counter width $clog2(W)
- Sub-module fullsubtractor with ports bi, a, b, d, bo. It is purely combinational and is the only arithmetic in the serial path.
- The top level holds the FSM, counter, operand/result shift registers, borrow flop, and output registers. The magnitude negation (~diff+1) is computed in the top level at the DONE transition.

## Test plan
- a=9, b=3, start for 1 cycle → done exactly 4 clocks after the accepting edge and 1 cycle wide; diff=6, borrow=0, neg=0, mag=6; busy high for 4 cycles.
- a=3, b=9 → diff=4'hA, borrow=1, neg=1, mag=6. Then a=0, b=15 → diff=1, borrow=1, mag=15.
- a=5, b=5 → diff=0, borrow=0, mag=0. Then a=0, b=8 → diff=8, borrow=1, mag=8.
- a=12, b=4 accepted, then start pulsed in the 2nd SHIFT cycle with a=1, b=2 → a single done with diff=8. Also, start held high continuously → done pulses every 6 clocks.
- rst_n low during the 2nd SHIFT cycle → the next edge gives all outputs 0 and busy=0, with no done ever. Then a=7, b=2 → diff=5 at normal latency.
- W=8: a=8'h10, b=8'h20 → done after 8 clocks; diff=8'hF0, borrow=1, mag=8'h10.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int W_DEFAULT = 4;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(W_DEFAULT);

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// Single-bit full subtractor: the only arithmetic in the serial datapath.
module fullsubtractor (
    input  logic bi,
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, with registered borrow and
// sign/magnitude outputs for display.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         neg,
    output logic [W-1:0] mag
);

    localparam int CW = cnt_width(W);

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic [W-1:0]  rd;
    logic          br;
    logic [CW-1:0] cnt;
    logic          bit_d;
    logic          bit_bo;
    logic          last_bit;
    logic [W-1:0]  diff_new;

    fullsubtractor u_fs (
        .bi (br),
        .a  (ra[0]),
        .b  (rb[0]),
        .d  (bit_d),
        .bo (bit_bo)
    );

    assign last_bit = (cnt == CW'(W - 1));
    assign diff_new = {bit_d, rd[W-1:1]};
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result registers only change on the final bit, so the display never
    // shows a partially shifted value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            rd     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            neg    <= 1'b0;
            mag    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        rd  <= '0;
                        br  <= 1'b0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    rd  <= diff_new;
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    br  <= bit_bo;
                    cnt <= cnt + CW'(1);
                    if (last_bit) begin
                        diff   <= diff_new;
                        borrow <= bit_bo;
                        neg    <= bit_bo;
                        mag    <= bit_bo ? (~diff_new + W'(1)) : diff_new;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at W=4, plus a directed W=8 case.
module tb_serial_subtractor;

    localparam int W  = 4;
    localparam int W8 = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  diff;
    logic          borrow;
    logic          neg;
    logic [W-1:0]  mag;

    logic          start8;
    logic [W8-1:0] a8;
    logic [W8-1:0] b8;
    logic          busy8;
    logic          done8;
    logic [W8-1:0] diff8;
    logic          borrow8;
    logic          neg8;
    logic [W8-1:0] mag8;

    int tests_run  = 0;
    int tests_fail = 0;
    int cyc        = 0;
    int pushes     = 0;
    int dones_seen = 0;
    int busy_cnt   = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic [W-1:0] mag;
        int           acc;
    } exp_t;

    exp_t sb[$];

    serial_subtractor #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .neg    (neg),
        .mag    (mag)
    );

    serial_subtractor #(.W(W8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8),
        .neg    (neg8),
        .mag    (mag8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    // Reference arithmetic for one W-bit operation.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input int acc);
        exp_t e;
        int   ix = int'(x);
        int   iy = int'(y);
        e.diff   = W'((ix - iy + (1 << W)) % (1 << W));
        e.borrow = (ix < iy);
        e.mag    = W'((ix < iy) ? (iy - ix) : (ix - iy));
        e.acc    = acc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                exp_t e;
                dones_seen++;
                checkOutput("done_width", {31'd0, prev_done}, 32'd0);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("latency", cyc - e.acc, W);
                    checkOutput("busy_cycles", busy_cnt, W);
                    checkOutput("diff", {28'd0, diff}, {28'd0, e.diff});
                    checkOutput("borrow", {31'd0, borrow}, {31'd0, e.borrow});
                    checkOutput("neg", {31'd0, neg}, {31'd0, e.borrow});
                    checkOutput("mag", {28'd0, mag}, {28'd0, e.mag});
                end
                busy_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input bit push);
        waitIdle();
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~x;
        b     = ~y;
        if (push) begin
            sb.push_back(model(x, y, cyc));
            pushes++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("sb_drained", sb.size(), 32'd0);
    endtask

    initial begin
        int acc;
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_diff", {28'd0, diff}, 32'd0);
        checkOutput("rst_borrow", {31'd0, borrow}, 32'd0);
        checkOutput("rst_neg", {31'd0, neg}, 32'd0);
        checkOutput("rst_mag", {28'd0, mag}, 32'd0);
        rst_n = 1'b1;

        applyStimulus(4'd9, 4'd3, 1'b1);
        applyStimulus(4'd3, 4'd9, 1'b1);
        applyStimulus(4'd0, 4'd15, 1'b1);
        applyStimulus(4'd5, 4'd5, 1'b1);
        applyStimulus(4'd0, 4'd8, 1'b1);
        for (int i = 0; i < 8; i++)
            applyStimulus(4'($urandom_range(15)), 4'($urandom_range(15)), 1'b1);
        drain();

        // A start pulse during SHIFT must be dropped, not queued.
        applyStimulus(4'd12, 4'd4, 1'b1);
        @(posedge clk);
        #1;
        a     = 4'd1;
        b     = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (10) @(posedge clk);

        // Start held high: accepts every W+2 clocks.
        waitIdle();
        a     = 4'd6;
        b     = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        sb.push_back(model(4'd6, 4'd1, acc));
        pushes++;
        a = 4'd2;
        b = 4'd11;
        for (int k = 1; k < 3; k++) begin
            repeat (W + 2) @(posedge clk);
            #1;
            sb.push_back(model(a, b, acc + k * (W + 2)));
            pushes++;
            a = a + 4'd7;
            b = b + 4'd3;
        end
        start = 1'b0;
        drain();

        // Reset in the middle of an operation aborts it with no done.
        applyStimulus(4'd13, 4'd2, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_diff", {28'd0, diff}, 32'd0);
        checkOutput("abort_borrow", {31'd0, borrow}, 32'd0);
        checkOutput("abort_mag", {28'd0, mag}, 32'd0);
        rst_n = 1'b1;
        repeat (W + 4) @(posedge clk);
        applyStimulus(4'd7, 4'd2, 1'b1);
        drain();
        repeat (4) @(posedge clk);
        checkOutput("done_count", dones_seen, pushes);

        // Wider instance.
        @(negedge clk);
        a8     = 8'h10;
        b8     = 8'h20;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        acc    = cyc;
        n      = 0;
        @(negedge clk);
        while (!done8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("w8_latency", cyc - acc, W8);
        checkOutput("w8_diff", {24'd0, diff8}, 32'h0000_00F0);
        checkOutput("w8_borrow", {31'd0, borrow8}, 32'd1);
        checkOutput("w8_neg", {31'd0, neg8}, 32'd1);
        checkOutput("w8_mag", {24'd0, mag8}, 32'h0000_0010);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
